reg_bank: RTL and testbench

- Parametrised successor to the single 16-bit load register.
- Holds DEPTH words of WIDTH bits each.
- One write port with load control and one registered read port with 1-cycle latency.
- Per-word "written" flags, and a synchronous bulk clear.
- Used as the general-purpose memory/register-file building block for the CPU datapath and RAM hierarchy.

---
 rtl/reg_bank.sv | 146 ++++++++++++++
 tb/tb_reg_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with one write port, one registered
// read port (1-cycle latency), per-word written flags and a synchronous
// bulk clear.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset of all state
//   in           write data
//   load         write enable, captures in at address on clk rise
//   address      word address shared by the write and read paths
//   rd_en        read request, result presented the next cycle
//   clear        synchronous clear of all words and flags (beats load)
//   out          registered read data (holds while no read is issued)
//   out_valid    one-cycle strobe following each accepted read
//   out_written  written flag of the word read (holds like out)
//   addr_err     read address was >= DEPTH, strobed with out_valid
//
// Optional build macro REG_BANK_PARITY_EN
//   adds a stored even-parity bit per word, output parity_err (strobed
//   with out_valid on a stored parity mismatch) and the test hook input
//   inj_err, which inverts the parity bit stored by a write.

module reg_bank #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              rd_en,
   input  logic              clear,
`ifdef REG_BANK_PARITY_EN
   input  logic              inj_err,
   output logic              parity_err,
`endif
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              out_written,
   output logic              addr_err
);

   // DEPTH always fits in one bit more than the address, even when DEPTH
   // is an exact power of two.
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written;

   logic             addr_ok;
   logic             wr_hit;
   logic [WIDTH-1:0] rd_data;
   logic             rd_flag;

   assign addr_ok = ({1'b0, address} < DEPTH_C);
   assign wr_hit  = load & ~clear & addr_ok;

   // Read-side view of the word as it will look after this edge:
   // clear wins, then a same-cycle write (write-first), then storage.
   always_comb begin
      rd_data = '0;
      rd_flag = 1'b0;
      if (addr_ok && !clear) begin
         if (load) begin
            rd_data = in;
            rd_flag = 1'b1;
         end else begin
            rd_data = mem[address];
            rd_flag = written[address];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written <= '0;
      end else if (wr_hit) begin
         mem[address]     <= in;
         written[address] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out         <= '0;
         out_written <= 1'b0;
         out_valid   <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         out_valid <= rd_en;
         addr_err  <= rd_en & ~addr_ok;
         if (rd_en) begin
            out         <= rd_data;
            out_written <= rd_flag;
         end
      end
   end

`ifdef REG_BANK_PARITY_EN
   logic [DEPTH-1:0] par;
   logic             rd_perr;

   // Zero data with a zero parity bit is consistent, so clear/reset only
   // need to zero the parity bits. On a write-first read the stored bit
   // would be ^in ^ inj_err, so the mismatch is inj_err itself.
   always_comb begin
      rd_perr = 1'b0;
      if (addr_ok && !clear) begin
         if (load) begin
            rd_perr = inj_err;
         end else begin
            rd_perr = par[address] ^ (^mem[address]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par <= '0;
      end else if (clear) begin
         par <= '0;
      end else if (wr_hit) begin
         par[address] <= (^in) ^ inj_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= rd_en & rd_perr;
      end
   end
`endif

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        reset;

   logic [15:0] din;
   logic        load, clear, rd_en;
   logic [2:0]  addr;
   logic [15:0] out;
   logic        out_valid, out_written, addr_err;

   logic [15:0] din6;
   logic        load6, clear6, rd6;
   logic [2:0]  addr6;
   logic [15:0] out6;
   logic        valid6, written6, err6;

`ifdef REG_BANK_PARITY_EN
   logic inj_err, parity_err, inj6, perr6;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .in(din), .load(load), .address(addr),
      .rd_en(rd_en), .clear(clear),
`ifdef REG_BANK_PARITY_EN
      .inj_err(inj_err), .parity_err(parity_err),
`endif
      .out(out), .out_valid(out_valid), .out_written(out_written),
      .addr_err(addr_err)
   );

   reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
      .clk(clk), .reset(reset), .in(din6), .load(load6), .address(addr6),
      .rd_en(rd6), .clear(clear6),
`ifdef REG_BANK_PARITY_EN
      .inj_err(inj6), .parity_err(perr6),
`endif
      .out(out6), .out_valid(valid6), .out_written(written6),
      .addr_err(err6)
   );

   typedef struct {
      logic        ld, cl, rd;
      logic [2:0]  a;
      logic [15:0] d;
      logic        ev;
      logic [15:0] eo;
      logic        ew, ee;
   } vec_t;

   vec_t tbl[$];

   // reference model for the DEPTH=8 instance
   logic [15:0] m_mem  [8];
   logic        m_flag [8];
   logic [15:0] m_out;
   logic        m_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic mk(input logic ld, input logic cl, input logic rd, input logic [2:0] a,
                     input logic [15:0] d, input logic ev, input logic [15:0] eo,
                     input logic ew, input logic ee);
      vec_t v;
      v.ld = ld; v.cl = cl; v.rd = rd; v.a = a; v.d = d;
      v.ev = ev; v.eo = eo; v.ew = ew; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic apply(input logic ld, input logic cl, input logic rd,
                        input logic [2:0] a, input logic [15:0] d);
      load = ld; clear = cl; rd_en = rd; addr = a; din = d;
      @(posedge clk);
      #1;
      load = 1'b0; clear = 1'b0; rd_en = 1'b0;
   endtask

   task automatic apply6(input logic ld, input logic rd, input logic [2:0] a,
                         input logic [15:0] d);
      load6 = ld; rd6 = rd; addr6 = a; din6 = d;
      @(posedge clk);
      #1;
      load6 = 1'b0; rd6 = 1'b0;
   endtask

   task automatic chk6(input string name, input logic v, input logic [15:0] o,
                       input logic w, input logic e);
      chk({name, ".valid"},   32'(valid6),   32'(v));
      chk({name, ".out"},     32'(out6),     32'(o));
      chk({name, ".written"}, 32'(written6), 32'(w));
      chk({name, ".addr_err"},32'(err6),     32'(e));
   endtask

   initial begin
      reset = 1'b1;
      din = '0; load = 0; clear = 0; rd_en = 0; addr = '0;
      din6 = '0; load6 = 0; clear6 = 0; rd6 = 0; addr6 = '0;
`ifdef REG_BANK_PARITY_EN
      inj_err = 0; inj6 = 0;
`endif
      #2;
      chk("rst.out", 32'(out), 32'h0);
      chk("rst.valid", 32'(out_valid), 32'h0);
      chk("rst.written", 32'(out_written), 32'h0);
      chk("rst.addr_err", 32'(addr_err), 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // ---------------- table-driven directed vectors -----------------
      for (int i = 0; i < 8; i++) mk(0, 0, 1, 3'(i), 16'h0, 1, 16'h0, 0, 0);
      mk(1, 0, 0, 3, 16'hBEEF, 0, 16'h0,    0, 0);
      mk(0, 0, 1, 3, 16'h0,    1, 16'hBEEF, 1, 0);
      mk(0, 0, 1, 2, 16'h0,    1, 16'h0,    0, 0);
      mk(1, 0, 1, 5, 16'h1234, 1, 16'h1234, 1, 0);
      mk(0, 0, 0, 0, 16'h0,    0, 16'h1234, 1, 0);
      mk(1, 1, 1, 1, 16'h5555, 1, 16'h0,    0, 0);
      mk(0, 0, 1, 3, 16'h0,    1, 16'h0,    0, 0);
      mk(0, 0, 1, 5, 16'h0,    1, 16'h0,    0, 0);
      for (int i = 0; i < 8; i++) mk(1, 0, 0, 3'(i), 16'hFFFF, 0, 16'h0, 0, 0);
      mk(0, 0, 1, 6, 16'h0,    1, 16'hFFFF, 1, 0);
      mk(1, 1, 0, 1, 16'h5555, 0, 16'hFFFF, 1, 0);
      mk(0, 0, 1, 1, 16'h0,    1, 16'h0,    0, 0);
      mk(0, 0, 1, 7, 16'h0,    1, 16'h0,    0, 0);

      foreach (tbl[k]) begin
         apply(tbl[k].ld, tbl[k].cl, tbl[k].rd, tbl[k].a, tbl[k].d);
         chk($sformatf("vec%0d.valid", k),    32'(out_valid),   32'(tbl[k].ev));
         chk($sformatf("vec%0d.out", k),      32'(out),         32'(tbl[k].eo));
         chk($sformatf("vec%0d.written", k),  32'(out_written), 32'(tbl[k].ew));
         chk($sformatf("vec%0d.addr_err", k), 32'(addr_err),    32'(tbl[k].ee));
      end

      // ---------------- randomized against reference model ------------
      m_out = 16'h0; m_wr = 1'b0;
      for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_flag[i] = 1'b0; end
      for (int c = 0; c < 300; c++) begin
         logic        ld, cl, rd, ev;
         logic [2:0]  a;
         logic [15:0] d;
         ld = ($urandom_range(0, 1) == 1);
         cl = (c == 0) || ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 9) < 6);
         a  = 3'($urandom_range(0, 7));
         d  = 16'($urandom);
         ev = rd;
         if (rd) begin
            if (cl)      begin m_out = 16'h0; m_wr = 1'b0; end
            else if (ld) begin m_out = d;     m_wr = 1'b1; end
            else         begin m_out = m_mem[a]; m_wr = m_flag[a]; end
         end
         if (cl) begin
            for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_flag[i] = 1'b0; end
         end else if (ld) begin
            m_mem[a] = d; m_flag[a] = 1'b1;
         end
         apply(ld, cl, rd, a, d);
         chk("rnd.valid",    32'(out_valid),   32'(ev));
         chk("rnd.out",      32'(out),         32'(m_out));
         chk("rnd.written",  32'(out_written), 32'(m_wr));
         chk("rnd.addr_err", 32'(addr_err),    32'h0);
`ifdef REG_BANK_PARITY_EN
         chk("rnd.parity_err", 32'(parity_err), 32'h0);
`endif
      end

      // ---------------- DEPTH=6: out-of-range addresses ---------------
      apply6(1, 0, 7, 16'hAAAA);
      apply6(0, 1, 7, 16'h0);       chk6("d6.rd7", 1, 16'h0, 0, 1);
      apply6(1, 1, 6, 16'h4321);    chk6("d6.wr6rd6", 1, 16'h0, 0, 1);
      apply6(1, 0, 2, 16'h1357);
      apply6(0, 1, 2, 16'h0);       chk6("d6.rd2", 1, 16'h1357, 1, 0);
      apply6(0, 0, 0, 16'h0);       chk6("d6.idle", 0, 16'h1357, 1, 0);
      for (int i = 0; i < 6; i++) begin
         if (i != 2) begin
            apply6(0, 1, 3'(i), 16'h0);
            chk6($sformatf("d6.rd%0d", i), 1, 16'h0, 0, 0);
         end
      end

`ifdef REG_BANK_PARITY_EN
      // ---------------- parity error injection ------------------------
      inj_err = 1'b1;
      apply(1, 0, 0, 2, 16'h0F0F);
      inj_err = 1'b0;
      apply(0, 0, 1, 2, 16'h0);
      chk("par.inj", 32'(parity_err), 32'h1);
      apply(1, 0, 0, 2, 16'h0F0F);
      apply(0, 0, 1, 2, 16'h0);
      chk("par.clean", 32'(parity_err), 32'h0);
      inj_err = 1'b1;
      apply(1, 0, 1, 3, 16'h0001);
      inj_err = 1'b0;
      chk("par.wfirst", 32'(parity_err), 32'h1);
`endif

      // ---------------- asynchronous reset mid-operation --------------
      apply(1, 0, 0, 4, 16'hC0DE);
      rd_en = 1'b1; addr = 3'd4;
      @(posedge clk);
      #1 rd_en = 1'b0;
      chk("arst.pre_valid", 32'(out_valid), 32'h1);
      chk("arst.pre_out",   32'(out),       32'hC0DE);
      #2 reset = 1'b1;
      #1;
      chk("arst.valid",   32'(out_valid),   32'h0);
      chk("arst.out",     32'(out),         32'h0);
      chk("arst.written", 32'(out_written), 32'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      apply(0, 0, 1, 4, 16'h0);
      chk("arst.rd_valid",   32'(out_valid),   32'h1);
      chk("arst.rd_out",     32'(out),         32'h0);
      chk("arst.rd_written", 32'(out_written), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
